ysyx_24110006_axi_arbiter: RTL and testbench

YSYX_24110006_AXI_ARBITER -- requirements
Module: ysyx_24110006_axi_arbiter

---
 rtl/ysyx_24110006_pkg.sv | 24 ++
 rtl/ysyx_24110006_arb_perf_cnt.sv | 23 ++
 rtl/ysyx_24110006_axi_arbiter.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_24110006_axi_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24110006_pkg.sv
// Shared types and AXI constants for the ysyx_24110006 AXI arbiter slice.
package ysyx_24110006_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } arb_state_e;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LSU = 1'b1
    } rd_src_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/ysyx_24110006_arb_perf_cnt.sv
// Saturating 32-bit stall counter with a synchronous load used for presetting.
module ysyx_24110006_arb_perf_cnt
    import ysyx_24110006_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != PERF_MAX)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// Single-outstanding AXI4 arbiter: IFU burst reads and LSU single-beat reads/writes onto one master port.
// Stall counters are built only when YSYX_24110006_ARB_PERF_EN is defined.
module ysyx_24110006_axi_arbiter
    import ysyx_24110006_pkg::*;
#(
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] LSU_ID = 4'd1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,

    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_awaddr,
    input  logic [2:0]  lsu_awsize,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [1:0]  lsu_bresp,

    input  logic        io_master_awready,
    output logic        io_master_awvalid,
    output logic [31:0] io_master_awaddr,
    output logic [3:0]  io_master_awid,
    output logic [7:0]  io_master_awlen,
    output logic [2:0]  io_master_awsize,
    output logic [1:0]  io_master_awburst,
    input  logic        io_master_wready,
    output logic        io_master_wvalid,
    output logic [31:0] io_master_wdata,
    output logic [3:0]  io_master_wstrb,
    output logic        io_master_wlast,
    output logic        io_master_bready,
    input  logic        io_master_bvalid,
    input  logic [1:0]  io_master_bresp,
    input  logic [3:0]  io_master_bid,
    input  logic        io_master_arready,
    output logic        io_master_arvalid,
    output logic [31:0] io_master_araddr,
    output logic [3:0]  io_master_arid,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    output logic        io_master_rready,
    input  logic        io_master_rvalid,
    input  logic [1:0]  io_master_rresp,
    input  logic [31:0] io_master_rdata,
    input  logic        io_master_rlast,
    input  logic [3:0]  io_master_rid,

    output logic [31:0] perf_ifu_wait,
    output logic [31:0] perf_lsu_wait
);

    arb_state_e state, state_nxt;
    rd_src_e    last_rd;
    logic       ar_done, aw_done, w_done;
    logic       b_allowed;
    logic       unused_ids;

    assign unused_ids = ^{io_master_bid, io_master_rid};

    assign ifu_rdata = io_master_rdata;
    assign ifu_rresp = io_master_rresp;
    assign ifu_rlast = io_master_rlast;
    assign lsu_rdata = io_master_rdata;
    assign lsu_rresp = io_master_rresp;
    assign lsu_bresp = io_master_bresp;

    assign io_master_awaddr  = lsu_awaddr;
    assign io_master_awid    = LSU_ID;
    assign io_master_awlen   = '0;
    assign io_master_awsize  = lsu_awsize;
    assign io_master_awburst = AXI_BURST_INCR;
    assign io_master_wdata   = lsu_wdata;
    assign io_master_wstrb   = lsu_wstrb;
    assign io_master_wlast   = (state == WR_LSU);

    assign b_allowed = aw_done && w_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        io_master_arvalid = 1'b0;
        io_master_araddr  = ifu_araddr;
        io_master_arid    = IFU_ID;
        io_master_arlen   = ifu_arlen;
        io_master_arsize  = ifu_arsize;
        io_master_arburst = ifu_arburst;
        io_master_rready  = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        ifu_arready       = 1'b0;
        ifu_rvalid        = 1'b0;
        lsu_arready       = 1'b0;
        lsu_rvalid        = 1'b0;
        lsu_awready       = 1'b0;
        lsu_wready        = 1'b0;
        lsu_bvalid        = 1'b0;
        case (state)
            IDLE: begin
                // Writes pre-empt reads; ties between reads go to whoever was not served last.
                if (lsu_awvalid) begin
                    state_nxt = WR_LSU;
                end else if (ifu_arvalid && (!lsu_arvalid || last_rd == SRC_LSU)) begin
                    state_nxt = RD_IFU;
                end else if (lsu_arvalid) begin
                    state_nxt = RD_LSU;
                end
            end
            RD_IFU: begin
                io_master_arvalid = ifu_arvalid && !ar_done;
                ifu_arready       = io_master_arready && !ar_done;
                io_master_rready  = ifu_rready;
                ifu_rvalid        = io_master_rvalid;
                if (io_master_rvalid && ifu_rready && io_master_rlast) begin
                    state_nxt = IDLE;
                end
            end
            RD_LSU: begin
                io_master_arvalid = lsu_arvalid && !ar_done;
                io_master_araddr  = lsu_araddr;
                io_master_arid    = LSU_ID;
                io_master_arlen   = '0;
                io_master_arsize  = lsu_arsize;
                io_master_arburst = AXI_BURST_INCR;
                lsu_arready       = io_master_arready && !ar_done;
                io_master_rready  = lsu_rready;
                lsu_rvalid        = io_master_rvalid;
                if (io_master_rvalid && lsu_rready && io_master_rlast) begin
                    state_nxt = IDLE;
                end
            end
            WR_LSU: begin
                io_master_awvalid = lsu_awvalid && !aw_done;
                lsu_awready       = io_master_awready && !aw_done;
                io_master_wvalid  = lsu_wvalid && !w_done;
                lsu_wready        = io_master_wready && !w_done;
                io_master_bready  = lsu_bready && b_allowed;
                lsu_bvalid        = io_master_bvalid && b_allowed;
                if (io_master_bvalid && lsu_bready && b_allowed) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are cleared during the mandatory IDLE cycle between transactions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            last_rd <= SRC_LSU;
        end else if (state == IDLE) begin
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (state_nxt == RD_IFU) begin
                last_rd <= SRC_IFU;
            end else if (state_nxt == RD_LSU) begin
                last_rd <= SRC_LSU;
            end
        end else begin
            if (io_master_arvalid && io_master_arready) ar_done <= 1'b1;
            if (io_master_awvalid && io_master_awready) aw_done <= 1'b1;
            if (io_master_wvalid && io_master_wready)   w_done  <= 1'b1;
        end
    end

`ifdef YSYX_24110006_ARB_PERF_EN
    logic ifu_wait, lsu_wait;

    assign ifu_wait = ifu_arvalid && !ifu_arready;
    assign lsu_wait = (lsu_arvalid && !lsu_arready) ||
                      (lsu_awvalid && !lsu_awready) ||
                      (lsu_wvalid  && !lsu_wready);

    ysyx_24110006_arb_perf_cnt u_ifu_perf (
        .clock    (clock),
        .reset    (reset),
        .inc      (ifu_wait),
        .load     (1'b0),
        .load_val ('0),
        .count    (perf_ifu_wait)
    );

    ysyx_24110006_arb_perf_cnt u_lsu_perf (
        .clock    (clock),
        .reset    (reset),
        .inc      (lsu_wait),
        .load     (1'b0),
        .load_val ('0),
        .count    (perf_lsu_wait)
    );
`else
    assign perf_ifu_wait = '0;
    assign perf_lsu_wait = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// Directed self-checking bench for ysyx_24110006_axi_arbiter; perf expectations follow YSYX_24110006_ARB_PERF_EN.
module tb_ysyx_24110006_axi_arbiter;

    localparam logic [3:0] T_IFU_ID = 4'd0;
    localparam logic [3:0] T_LSU_ID = 4'd1;

    logic        clock, reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_arsize, lsu_awsize;
    logic [1:0]  lsu_rresp, lsu_bresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [3:0]  lsu_wstrb;
    logic        io_master_awready, io_master_awvalid, io_master_wready, io_master_wvalid, io_master_wlast;
    logic [31:0] io_master_awaddr, io_master_wdata, io_master_araddr, io_master_rdata;
    logic [3:0]  io_master_awid, io_master_wstrb, io_master_bid, io_master_arid, io_master_rid;
    logic [7:0]  io_master_awlen, io_master_arlen;
    logic [2:0]  io_master_awsize, io_master_arsize;
    logic [1:0]  io_master_awburst, io_master_bresp, io_master_arburst, io_master_rresp;
    logic        io_master_bready, io_master_bvalid, io_master_arready, io_master_arvalid;
    logic        io_master_rready, io_master_rvalid, io_master_rlast;
    logic [31:0] perf_ifu_wait, perf_lsu_wait;

    logic        sat_rst, sat_inc, sat_load;
    logic [31:0] sat_val, sat_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef YSYX_24110006_ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    ysyx_24110006_axi_arbiter #(.IFU_ID(T_IFU_ID), .LSU_ID(T_LSU_ID)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
        .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
        .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .io_master_awready(io_master_awready), .io_master_awvalid(io_master_awvalid),
        .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst), .io_master_wready(io_master_wready),
        .io_master_wvalid(io_master_wvalid), .io_master_wdata(io_master_wdata),
        .io_master_wstrb(io_master_wstrb), .io_master_wlast(io_master_wlast),
        .io_master_bready(io_master_bready), .io_master_bvalid(io_master_bvalid),
        .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
        .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
        .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
        .io_master_rid(io_master_rid),
        .perf_ifu_wait(perf_ifu_wait), .perf_lsu_wait(perf_lsu_wait)
    );

    ysyx_24110006_arb_perf_cnt u_sat (
        .clock(clock), .reset(sat_rst), .inc(sat_inc),
        .load(sat_load), .load_val(sat_val), .count(sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_arvalid = 0; ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = '0; ifu_arburst = '0;
        ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = '0; lsu_awsize = '0;
        lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 0;
        io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0; io_master_bresp = '0;
        io_master_bid = '0; io_master_arready = 0; io_master_rvalid = 0; io_master_rresp = '0;
        io_master_rdata = '0; io_master_rlast = 0; io_master_rid = '0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
    endtask

    // Assumes the granted read state was just entered; completes AR then all R beats.
    task automatic serve_read(input logic is_ifu, input logic [31:0] addr,
                              input int unsigned beats, input logic [1:0] resp);
        io_master_arready = 1;
        #1;
        check("ar_valid", 32'(io_master_arvalid), 32'd1);
        check("ar_id", 32'(io_master_arid), 32'(is_ifu ? T_IFU_ID : T_LSU_ID));
        check("ar_addr", io_master_araddr, addr);
        check("ar_len", 32'(io_master_arlen), is_ifu ? beats - 1 : 32'd0);
        check("ar_burst", 32'(io_master_arburst), 32'(is_ifu ? ifu_arburst : 2'b01));
        check("ar_size", 32'(io_master_arsize), 32'(is_ifu ? ifu_arsize : lsu_arsize));
        check("ifu_arready", 32'(ifu_arready), 32'(is_ifu));
        check("lsu_arready", 32'(lsu_arready), 32'(!is_ifu));
        tick();
        io_master_arready = 0;
        if (is_ifu) ifu_arvalid = 0; else lsu_arvalid = 0;
        for (int unsigned b = 0; b < beats; b++) begin
            io_master_rvalid = 1;
            io_master_rdata  = 32'hD000_0000 + b;
            io_master_rresp  = resp;
            io_master_rlast  = (b == beats - 1);
            ifu_rready = 1;
            lsu_rready = 1;
            #1;
            check("ar_dropped", 32'(io_master_arvalid), 32'd0);
            check("r_ready", 32'(io_master_rready), 32'd1);
            if (is_ifu) begin
                check("ifu_rvalid", 32'(ifu_rvalid), 32'd1);
                check("ifu_rdata", ifu_rdata, 32'hD000_0000 + b);
                check("ifu_rresp", 32'(ifu_rresp), 32'(resp));
                check("ifu_rlast", 32'(ifu_rlast), 32'(b == beats - 1));
                check("lsu_rvalid_off", 32'(lsu_rvalid), 32'd0);
            end else begin
                check("lsu_rvalid", 32'(lsu_rvalid), 32'd1);
                check("lsu_rdata", lsu_rdata, 32'hD000_0000 + b);
                check("lsu_rresp", 32'(lsu_rresp), 32'(resp));
                check("ifu_rvalid_off", 32'(ifu_rvalid), 32'd0);
            end
            tick();
        end
        io_master_rvalid = 0;
        io_master_rlast  = 0;
        #1;
        check("idle_rready", 32'(io_master_rready), 32'd0);
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        sat_rst = 1; sat_inc = 0; sat_load = 0; sat_val = '0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state
        check("rst_arvalid", 32'(io_master_arvalid), 32'd0);
        check("rst_awvalid", 32'(io_master_awvalid), 32'd0);
        check("rst_wvalid", 32'(io_master_wvalid), 32'd0);
        check("rst_rready", 32'(io_master_rready), 32'd0);
        check("rst_bready", 32'(io_master_bready), 32'd0);
        check("rst_perf_ifu", perf_ifu_wait, 32'd0);
        check("rst_perf_lsu", perf_lsu_wait, 32'd0);
        check("sat_rst", sat_count, 32'd0);

        // Saturating counter preset near max
        sat_rst = 0; sat_load = 1; sat_val = 32'hFFFF_FFFD;
        tick();
        sat_load = 0;
        check("sat_load", sat_count, 32'hFFFF_FFFD);
        sat_inc = 1;
        tick();
        check("sat_inc1", sat_count, 32'hFFFF_FFFE);
        repeat (4) tick();
        check("sat_hold", sat_count, 32'hFFFF_FFFF);
        sat_inc = 0;
        sat_rst = 1;
        #1;
        check("sat_async_rst", sat_count, 32'd0);
        sat_rst = 0;

        // IFU 4-beat burst
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000; ifu_arlen = 8'd3;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01; io_master_arready = 1;
        #1;
        check("ifu_ready_pre_grant", 32'(ifu_arready), 32'd0);
        check("arvalid_pre_grant", 32'(io_master_arvalid), 32'd0);
        tick();
        serve_read(1'b1, 32'h3000_0000, 4, 2'b00);

        // Round-robin alternation from reset
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0040; ifu_arlen = 8'd0;
        ifu_arsize = 3'd2; ifu_arburst = 2'b10;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0100; lsu_arsize = 3'd1;
        tick();
        serve_read(1'b1, 32'h3000_0040, 1, 2'b00);
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0080;
        #1;
        check("bubble_arvalid", 32'(io_master_arvalid), 32'd0);
        check("bubble_lsu_arready", 32'(lsu_arready), 32'd0);
        tick();
        serve_read(1'b0, 32'h8000_0100, 1, 2'b10);
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
        tick();
        serve_read(1'b1, 32'h3000_0080, 1, 2'b00);
        tick();
        serve_read(1'b0, 32'h8000_0200, 1, 2'b00);

        // Write with W accepted two cycles before AW, early B ignored, SLVERR forwarded
        do_reset();
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010; lsu_awsize = 3'd2;
        lsu_wvalid = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'hF; lsu_bready = 1;
        tick();
        io_master_wready = 1;
        #1;
        check("w_valid", 32'(io_master_wvalid), 32'd1);
        check("w_data", io_master_wdata, 32'hCAFE_F00D);
        check("w_strb", 32'(io_master_wstrb), 32'hF);
        check("w_last", 32'(io_master_wlast), 32'd1);
        check("aw_valid", 32'(io_master_awvalid), 32'd1);
        check("aw_id_len_burst", {20'd0, io_master_awid, io_master_awlen},
              {20'd0, T_LSU_ID, 8'd0});
        check("aw_burst", 32'(io_master_awburst), 32'd1);
        check("aw_addr", io_master_awaddr, 32'h8000_0010);
        check("lsu_awready_wait", 32'(lsu_awready), 32'd0);
        tick();
        io_master_bvalid = 1; io_master_bresp = 2'b00;
        #1;
        check("w_dropped", 32'(io_master_wvalid), 32'd0);
        check("lsu_wready_dropped", 32'(lsu_wready), 32'd0);
        check("early_b_hidden", 32'(lsu_bvalid), 32'd0);
        check("early_bready", 32'(io_master_bready), 32'd0);
        tick();
        io_master_bvalid = 0; io_master_awready = 1;
        #1;
        check("lsu_awready", 32'(lsu_awready), 32'd1);
        check("bready_before_aw", 32'(io_master_bready), 32'd0);
        tick();
        lsu_awvalid = 0; lsu_wvalid = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_bvalid = 1; io_master_bresp = 2'b10;
        #1;
        check("aw_dropped", 32'(io_master_awvalid), 32'd0);
        check("lsu_bvalid", 32'(lsu_bvalid), 32'd1);
        check("lsu_bresp", 32'(lsu_bresp), 32'h2);
        check("b_ready", 32'(io_master_bready), 32'd1);
        tick();
        io_master_bvalid = 0;
        #1;
        check("post_b_bready", 32'(io_master_bready), 32'd0);

        // Write pre-empts a simultaneous IFU read
        do_reset();
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_bready = 1;
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0100; ifu_arlen = 8'd0;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01;
        tick();
        io_master_awready = 1; io_master_wready = 1; io_master_arready = 1;
        #1;
        check("wr_first_awvalid", 32'(io_master_awvalid), 32'd1);
        check("wr_first_arvalid", 32'(io_master_arvalid), 32'd0);
        check("ifu_stall_wr", 32'(ifu_arready), 32'd0);
        tick();
        lsu_awvalid = 0; lsu_wvalid = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_bvalid = 1; io_master_bresp = 2'b00;
        #1;
        check("ifu_stall_b", 32'(ifu_arready), 32'd0);
        tick();
        io_master_bvalid = 0;
        #1;
        check("ifu_stall_bubble", 32'(ifu_arready), 32'd0);
        check("bubble_arvalid2", 32'(io_master_arvalid), 32'd0);
        tick();
        serve_read(1'b1, 32'h3000_0100, 1, 2'b00);

        // Reset during beat 2 of an IFU burst
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_1000; ifu_arlen = 8'd3;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01;
        tick();
        io_master_arready = 1;
        tick();
        io_master_arready = 0; ifu_arvalid = 0;
        io_master_rvalid = 1; io_master_rdata = 32'h1111_0000; ifu_rready = 1;
        tick();
        io_master_rdata = 32'h1111_0001;
        #1;
        check("beat2_rvalid", 32'(ifu_rvalid), 32'd1);
        reset = 1;
        #1;
        check("midrst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        check("midrst_rready", 32'(io_master_rready), 32'd0);
        check("midrst_arvalid", 32'(io_master_arvalid), 32'd0);
        check("midrst_ifu_arready", 32'(ifu_arready), 32'd0);
        io_master_rvalid = 0;
        tick();
        reset = 0;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0300; lsu_arsize = 3'd2;
        tick();
        serve_read(1'b0, 32'h8000_0300, 1, 2'b11);

        // Stall counters
        do_reset();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_2000; ifu_arlen = 8'd0;
        ifu_arsize = 3'd2; ifu_arburst = 2'b01;
        repeat (3) tick();
        check("perf_ifu_3", perf_ifu_wait, PERF_ON ? 32'd3 : 32'd0);
        repeat (2) tick();
        serve_read(1'b1, 32'h3000_2000, 1, 2'b00);
        check("perf_ifu_5", perf_ifu_wait, PERF_ON ? 32'd5 : 32'd0);
        check("perf_lsu_0", perf_lsu_wait, 32'd0);
        lsu_awvalid = 1; lsu_wvalid = 1; lsu_bready = 1;
        repeat (3) tick();
        io_master_awready = 1; io_master_wready = 1;
        tick();
        lsu_awvalid = 0; lsu_wvalid = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_bvalid = 1;
        tick();
        io_master_bvalid = 0;
        #1;
        check("perf_lsu_3", perf_lsu_wait, PERF_ON ? 32'd3 : 32'd0);
        check("perf_ifu_kept", perf_ifu_wait, PERF_ON ? 32'd5 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
